// File: rtl/tt_sweep_checker.sv
// Purpose: steps a 3-input block through all 8 vectors and checks its response against TT_CODE.
// Latency: SETTLE+1 cycles per vector; done rises 8*(SETTLE+1)+1 cycles after the start cycle.
// Backpressure: none; a start that arrives while busy is dropped, not queued.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              one-cycle sweep request (accepted in IDLE or DONE)
//   in1, in2, in3      registered drive of the current vector {in1,in2,in3}
//   dut_out            response of the block under test, possibly asynchronous to clk
//   busy, done, pass   sweep status; pass is meaningful only while done=1
//   measured_tt        captured truth table, vector 000 in the MSB
//   mismatch_mask      measured_tt ^ TT_CODE, valid once done=1
module tt_sweep_checker #(
    parameter logic [7:0]  TT_CODE = 8'h6B,
    parameter int unsigned SETTLE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] measured_tt,
    output logic [7:0] mismatch_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    state_t     state;
    logic [2:0] vec;
    logic [7:0] cnt;
    logic       sync1;
    logic       sync2;
    logic [7:0] tt_next;

    // dut_out may come from an unclocked block, so it is resynchronized before use.
    // Holding each vector at least two cycles before the sample lets the new response
    // reach sync2 in time.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= dut_out;
            sync2 <= sync1;
        end
    end

    // Captured table with the current sample dropped into its slot. On the final vector
    // this is the complete result, so the mask and pass can be registered on the same
    // edge that raises done.
    always_comb begin
        tt_next              = measured_tt;
        tt_next[3'd7 - vec]  = sync2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            vec           <= 3'd0;
            cnt           <= 8'd0;
            in1           <= 1'b0;
            in2           <= 1'b0;
            in3           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            measured_tt   <= 8'h00;
            mismatch_mask <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= HOLD;
                        vec             <= 3'd0;
                        cnt             <= 8'd0;
                        {in1, in2, in3} <= 3'd0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        measured_tt     <= 8'h00;
                        mismatch_mask   <= 8'h00;
                    end
                end

                HOLD: begin
                    if (cnt == SETTLE_C) begin
                        measured_tt <= tt_next;
                        cnt         <= 8'd0;
                        if (vec == 3'd7) begin
                            // vec stays at 7 here; it is reloaded on the next start.
                            state           <= DONE;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                            {in1, in2, in3} <= 3'd0;
                            mismatch_mask   <= tt_next ^ TT_CODE;
                            pass            <= (tt_next == TT_CODE);
                        end else begin
                            vec             <= vec + 3'd1;
                            {in1, in2, in3} <= vec + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

    logic       clk;
    logic       rst;

    // Instance A: SETTLE=4, block under test is a combinational lookup of but_tbl_a.
    logic       start;
    logic       a_in1, a_in2, a_in3;
    logic       a_dut;
    logic       a_busy, a_done, a_pass;
    logic [7:0] a_tt, a_mask;
    logic [7:0] but_tbl_a;
    logic [2:0] a_vec;

    // Instance B: SETTLE=2, block under test settles late in the cycle after its inputs move.
    logic       start_b;
    logic       b_in1, b_in2, b_in3;
    logic       b_dut;
    logic       b_busy, b_done, b_pass;
    logic [7:0] b_tt, b_mask;

    int n_cmp;
    int n_err;

    tt_sweep_checker #(.TT_CODE(8'h6B), .SETTLE(4)) u_a (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in1           (a_in1),
        .in2           (a_in2),
        .in3           (a_in3),
        .dut_out       (a_dut),
        .busy          (a_busy),
        .done          (a_done),
        .pass          (a_pass),
        .measured_tt   (a_tt),
        .mismatch_mask (a_mask)
    );

    tt_sweep_checker #(.TT_CODE(8'h6B), .SETTLE(2)) u_b (
        .clk           (clk),
        .rst           (rst),
        .start         (start_b),
        .in1           (b_in1),
        .in2           (b_in2),
        .in3           (b_in3),
        .dut_out       (b_dut),
        .busy          (b_busy),
        .done          (b_done),
        .pass          (b_pass),
        .measured_tt   (b_tt),
        .mismatch_mask (b_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_vec = {a_in1, a_in2, a_in3};
    assign a_dut = but_tbl_a[3'd7 - a_vec];

    // Correct 6B function, output lagging the inputs by 8 ns of a 10 ns cycle.
    function automatic logic good_fn(input logic [2:0] k);
        logic [7:0] tbl;
        tbl = 8'h6B;
        return tbl[3'd7 - k];
    endfunction

    initial b_dut = 1'b0;
    always @(b_in1 or b_in2 or b_in3) b_dut <= #8 good_fn({b_in1, b_in2, b_in3});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_vec"},  8'(a_vec), 8'd0);
        chk({tag, "_busy"}, 8'(a_busy), 8'd0);
        chk({tag, "_done"}, 8'(a_done), 8'd0);
        chk({tag, "_pass"}, 8'(a_pass), 8'd0);
        chk({tag, "_tt"},   a_tt, 8'h00);
        chk({tag, "_mask"}, a_mask, 8'h00);
    endtask

    // One sweep on instance A. Cycle 1 is the first cycle after the start edge;
    // vector v occupies cycles 5v+1..5v+5 and done appears in cycle 41.
    task automatic sweep_a(input string tag, input logic [7:0] exp_tt,
                           input logic [7:0] exp_mask, input logic exp_pass, input bit poke);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk({tag, "_vec"},  8'(a_vec), 8'((c - 1) / 5));
            chk({tag, "_busy"}, 8'(a_busy), 8'd1);
            chk({tag, "_done"}, 8'(a_done), 8'd0);
            // Vectors 0..2 are captured by cycle 16; vector 3 is not yet sampled.
            if (c == 18) chk({tag, "_partial"}, a_tt, exp_tt & 8'hE0);
            if (poke && c == 17) start = 1'b1;
            if (poke && c == 18) start = 1'b0;
            tick();
        end
        chk({tag, "_done_rise"}, 8'(a_done), 8'd1);
        chk({tag, "_busy_end"},  8'(a_busy), 8'd0);
        chk({tag, "_vec_end"},   8'(a_vec), 8'd0);
        chk({tag, "_tt"},        a_tt, exp_tt);
        chk({tag, "_mask"},      a_mask, exp_mask);
        chk({tag, "_pass"},      8'(a_pass), 8'(exp_pass));
        tick();
        tick();
        chk({tag, "_done_hold"}, 8'(a_done), 8'd1);
        chk({tag, "_tt_hold"},   a_tt, exp_tt);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        start     = 1'b0;
        start_b   = 1'b0;
        but_tbl_a = 8'h6B;

        // Reset dominates a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_busy", 8'(a_busy), 8'd0);
        end
        chk_a_reset("rst");
        chk("rst_b_busy", 8'(b_busy), 8'd0);
        chk("rst_b_tt",   b_tt, 8'h00);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", 8'(a_busy), 8'd0);

        // Correct block.
        but_tbl_a = 8'h6B;
        sweep_a("good", 8'h6B, 8'h00, 1'b1, 1'b0);

        // Stuck-at-0 block.
        but_tbl_a = 8'h00;
        sweep_a("sa0", 8'h00, 8'h6B, 1'b0, 1'b0);

        // Wrong only at vector 101.
        but_tbl_a = 8'h6F;
        sweep_a("f101", 8'h6F, 8'h04, 1'b0, 1'b0);

        // Abort during vector 5 (cycles 26..30).
        but_tbl_a = 8'h6B;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 27; c++) tick();
        chk("abort_vec", 8'(a_vec), 8'd5);
        chk("abort_partial", a_tt, 8'h68);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_a_reset("abort");
        tick();
        chk("abort_idle_busy", 8'(a_busy), 8'd0);
        chk("abort_idle_done", 8'(a_done), 8'd0);

        // Fresh sweep with a stray start inside vector 3.
        sweep_a("poke", 8'h6B, 8'h00, 1'b1, 1'b1);

        // Instance B: start held high, two back-to-back sweeps of 3 cycles per vector.
        start_b = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) begin
            for (int c = 1; c <= 25; c++) begin
                if (c <= 24) begin
                    chk("b_vec",  8'({b_in1, b_in2, b_in3}), 8'((c - 1) / 3));
                    chk("b_busy", 8'(b_busy), 8'd1);
                    chk("b_done", 8'(b_done), 8'd0);
                    if (c == 1) chk("b_cleared", b_tt, 8'h00);
                    tick();
                end else begin
                    chk("b_done_rise", 8'(b_done), 8'd1);
                    chk("b_tt",        b_tt, 8'h6B);
                    chk("b_mask",      b_mask, 8'h00);
                    chk("b_pass",      8'(b_pass), 8'd1);
                    if (s == 1) start_b = 1'b0;
                    tick();
                end
            end
        end
        chk("b_done_hold", 8'(b_done), 8'd1);
        chk("b_busy_hold", 8'(b_busy), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
